// File: rtl/cm_pkg_type.sv
// Shared byte/word types, lane count and keep-mask helpers for the byte packer.
package cm_pkg_type;

  localparam int unsigned CM_PACK_LANES = 4;
  localparam int unsigned LANE_W        = $clog2(CM_PACK_LANES);

  typedef logic [7:0]               u8;
  typedef logic [31:0]              u32;
  typedef logic [CM_PACK_LANES-1:0] keep_t;
  typedef logic [LANE_W-1:0]        lane_t;

  // Output payload carried through the register slice (37 bits).
  typedef struct packed {
    u32    data;
    keep_t keep;
    logic  last;
  } pack_word_t;

  localparam int unsigned PACK_WORD_W = $bits(pack_word_t);

  // Contiguous keep mask covering fill lanes 0..cnt.
  function automatic keep_t keep_upto(input lane_t cnt);
    keep_upto = CM_PACK_LANES'((5'd2 << cnt) - 5'd1);
  endfunction

endpackage

// File: rtl/cm_reg_slice.sv
// Single-entry valid/ready output register; upstream may load whenever the slot drains.
module cm_reg_slice #(
  parameter int unsigned W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/cm_byte_packer.sv
// Packs a byte stream into 32-bit words with keep/last; optional accepted-word
// counter o_words is enabled by defining CM_BYTE_PACKER_STAT_EN.
module cm_byte_packer
  import cm_pkg_type::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_data,
  output logic [3:0]  o_keep,
  output logic        o_last
`ifdef CM_BYTE_PACKER_STAT_EN
  ,
  output logic [31:0] o_words
`endif
);

  typedef enum logic {EMPTY, FILL} state_t;

  state_t     state;
  lane_t      count;
  u32         acc;
  logic       take_c;
  logic       flush_c;
  lane_t      pos_c;
  u32         merged_c;
  pack_word_t word_c;
  pack_word_t out_word;

  assign take_c  = i_valid && i_ready;
  assign flush_c = take_c && (i_last || count == lane_t'(CM_PACK_LANES - 1));
  assign pos_c   = MSB_FIRST ? lane_t'(CM_PACK_LANES - 1) - count : count;

  // A fresh word starts from zero so unused lanes of a partial flush read 0.
  always_comb begin
    merged_c = (state == EMPTY) ? '0 : acc;
    merged_c[{pos_c, 3'b000} +: 8] = u8'(i_data);
    word_c = '{data: merged_c, keep: keep_upto(count), last: i_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      count <= '0;
      acc   <= '0;
    end else if (take_c) begin
      if (flush_c) begin
        state <= EMPTY;
        count <= '0;
        acc   <= '0;
      end else begin
        state <= FILL;
        count <= count + lane_t'(1);
        acc   <= merged_c;
      end
    end
  end

  cm_reg_slice #(.W(PACK_WORD_W)) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .up_valid (flush_c),
    .up_ready (i_ready),
    .up_data  (word_c),
    .dn_valid (o_valid),
    .dn_ready (o_ready),
    .dn_data  (out_word)
  );

  assign o_data = out_word.data;
  assign o_keep = out_word.keep;
  assign o_last = out_word.last;

`ifdef CM_BYTE_PACKER_STAT_EN
  u32 word_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (o_valid && o_ready) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

  assign o_words = word_cnt;
`endif

endmodule
